// File: rtl/ext_pipe_if.sv
// ext_pipe_if: request/response bundle for the ext_pipe extension pipeline.
//   master : drives in_valid, src, mode, off, stall, flush; receives results
//   slave  : the pipeline side; receives requests, drives out_valid, ext_out,
//            misalign
// OFF_W is the byte-offset width: 2 for a 32-bit word, 3 for a 64-bit word.
interface ext_pipe_if #(
   parameter int DATA_W = 32
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   logic              in_valid;
   logic [DATA_W-1:0] src;
   logic [2:0]        mode;
   logic [OFF_W-1:0]  off;
   logic              stall;
   logic              flush;
   logic              out_valid;
   logic [DATA_W-1:0] ext_out;
   logic              misalign;

   modport master (
      output in_valid, src, mode, off, stall, flush,
      input  out_valid, ext_out, misalign
   );

   modport slave (
      input  in_valid, src, mode, off, stall, flush,
      output out_valid, ext_out, misalign
   );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: immediate / load-lane extension unit followed by a DEPTH-stage
// register pipeline with stall and flush.
//   clk   : sole clock, rising edge
//   reset : synchronous, active high; clears every stage (valid and data)
//   bus   : ext_pipe_if slave modport
//           in_valid/src/mode/off : request, extension done before stage 1
//           stall : hold every stage, input not sampled
//           flush : drop every in-flight request (beats stall)
//           out_valid/ext_out/misalign : last stage, fully registered
// Modes: 0 zext imm, 1 sext imm, 2 imm<<(DATA_W-IMM_W), 3/4 u/s byte lane off,
//        5/6 u/s half lane off[OFF_W-1:1], 7 pass src.
module ext_pipe #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1
) (
   input logic         clk,
   input logic         reset,
   ext_pipe_if.slave   bus
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   logic [IMM_W-1:0]  imm;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] ext_c;
   logic              mis_c;

   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
   logic [DEPTH-1:0]             mis_q, mis_d;

   assign imm      = bus.src[IMM_W-1:0];
   assign byte_sel = 8'(bus.src >> {bus.off, 3'b000});
   // off[0] is dropped for half accesses; a misaligned half still reads the
   // aligned half that contains the addressed byte.
   assign half_sel = 16'(bus.src >> {bus.off[OFF_W-1:1], 4'b0000});

   always_comb begin
      ext_c = '0;
      unique case (bus.mode)
         3'd0: ext_c[IMM_W-1:0] = imm;
         3'd1: ext_c = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
         3'd2: ext_c = {imm, {(DATA_W-IMM_W){1'b0}}};
         3'd3: ext_c = {{(DATA_W-8){1'b0}}, byte_sel};
         3'd4: ext_c = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         3'd5: ext_c = {{(DATA_W-16){1'b0}}, half_sel};
         3'd6: ext_c = {{(DATA_W-16){half_sel[15]}}, half_sel};
         3'd7: ext_c = bus.src;
         default: ext_c = '0;
      endcase
   end

   assign mis_c = ((bus.mode == 3'd5) || (bus.mode == 3'd6)) && bus.off[0];

   // Data registers only load when a valid entry moves into them, so the
   // output stage keeps its last result across bubbles and flushes.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      mis_d  = mis_q;
      if (bus.flush) begin
         vld_d = '0;
      end else if (!bus.stall) begin
         vld_d[0] = bus.in_valid;
         if (bus.in_valid) begin
            data_d[0] = ext_c;
            mis_d[0]  = mis_c;
         end
         for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
               data_d[i] = data_q[i-1];
               mis_d[i]  = mis_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= '0;
         data_q <= '0;
         mis_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         mis_q  <= mis_d;
      end
   end

   assign bus.out_valid = vld_q[DEPTH-1];
   assign bus.ext_out   = data_q[DEPTH-1];
   assign bus.misalign  = mis_q[DEPTH-1];
endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: vector table on a DEPTH=1 32-bit instance, directed
// multi-cycle sequences on DEPTH=3 (32-bit) and DEPTH=4 (64-bit, IMM_W=12)
// instances, and randomized traffic against a queue-based reference model.
module tb_ext_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   ext_pipe_if #(.DATA_W(32)) b1 ();
   ext_pipe_if #(.DATA_W(32)) b3 ();
   ext_pipe_if #(.DATA_W(64)) b4 ();

   ext_pipe #(.IMM_W(16), .DATA_W(32), .DEPTH(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
   ext_pipe #(.IMM_W(16), .DATA_W(32), .DEPTH(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
   ext_pipe #(.IMM_W(12), .DATA_W(64), .DEPTH(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));

   int checks = 0;
   int failures = 0;

   logic        ov, mi;
   logic [63:0] eo;

   typedef struct {
      logic [31:0] s;
      logic [2:0]  m;
      logic [1:0]  o;
      logic [31:0] e;
      logic        mi;
   } vec_t;

   typedef struct {
      logic        iv;
      logic [63:0] s;
      logic        st;
      logic        fl;
      logic        rst;
      logic        ev;
      logic [63:0] ed;
   } seq_t;

   typedef struct {
      logic [63:0] v;
      logic        m;
      int          age;
   } ent_t;

   seq_t sq[$];
   ent_t mq[$];
   logic        m_lv, m_lm;
   logic [63:0] m_le;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drv(input int sel, input logic iv, input logic [63:0] s, input logic [2:0] m,
                      input logic [2:0] o, input logic st, input logic fl);
      case (sel)
         1: begin b1.in_valid = iv; b1.src = s[31:0]; b1.mode = m; b1.off = o[1:0];
                  b1.stall = st; b1.flush = fl; end
         3: begin b3.in_valid = iv; b3.src = s[31:0]; b3.mode = m; b3.off = o[1:0];
                  b3.stall = st; b3.flush = fl; end
         default: begin b4.in_valid = iv; b4.src = s; b4.mode = m; b4.off = o;
                  b4.stall = st; b4.flush = fl; end
      endcase
   endtask

   task automatic get(input int sel);
      case (sel)
         1: begin ov = b1.out_valid; eo = {32'b0, b1.ext_out}; mi = b1.misalign; end
         3: begin ov = b3.out_valid; eo = {32'b0, b3.ext_out}; mi = b3.misalign; end
         default: begin ov = b4.out_valid; eo = b4.ext_out; mi = b4.misalign; end
      endcase
   endtask

   // Reference extension from the mode definitions, plain arithmetic on 64 bits.
   function automatic logic [63:0] ref_ext(input int dw, input int iw, input logic [2:0] mode,
                                           input int off, input logic [63:0] src);
      logic [63:0] dmask, imask, r, b, h;
      dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      imask = (64'd1 << iw) - 64'd1;
      b = (src >> (8 * off)) & 64'hFF;
      h = (src >> (16 * (off / 2))) & 64'hFFFF;
      case (mode)
         3'd0: r = src & imask;
         3'd1: r = src[iw-1] ? ((src & imask) | ~imask) : (src & imask);
         3'd2: r = (src & imask) << (dw - iw);
         3'd3: r = b;
         3'd4: r = b[7] ? (b | ~64'hFF) : b;
         3'd5: r = h;
         3'd6: r = h[15] ? (h | ~64'hFFFF) : h;
         default: r = src;
      endcase
      return r & dmask;
   endfunction

   // Model: each accepted request ages by one on every edge the pipe advances
   // and is visible once it has aged DEPTH-1 times; the last visible result
   // stays on ext_out/misalign until replaced or reset.
   task automatic m_step(input int depth, input logic rst, input logic iv, input logic st,
                         input logic fl, input logic [63:0] e, input logic m);
      ent_t n;
      if (rst) begin
         mq.delete();
         m_le = '0;
         m_lm = 1'b0;
      end else if (fl) begin
         mq.delete();
      end else if (!st) begin
         foreach (mq[i]) mq[i].age++;
         while (mq.size() > 0 && mq[0].age > depth - 1) void'(mq.pop_front());
         if (iv) begin
            n.v = e; n.m = m; n.age = 0;
            mq.push_back(n);
         end
      end
      m_lv = 1'b0;
      if (mq.size() > 0 && mq[0].age == depth - 1) begin
         m_lv = 1'b1;
         m_le = mq[0].v;
         m_lm = mq[0].m;
      end
   endtask

   task automatic add(input logic iv, input logic [63:0] s, input logic st, input logic fl,
                      input logic rst, input logic ev, input logic [63:0] ed);
      seq_t e;
      e.iv = iv; e.s = s; e.st = st; e.fl = fl; e.rst = rst; e.ev = ev; e.ed = ed;
      sq.push_back(e);
   endtask

   task automatic run_seq(input int sel, input string nm);
      foreach (sq[i]) begin
         reset = sq[i].rst;
         drv(sel, sq[i].iv, sq[i].s, 3'd7, 3'd0, sq[i].st, sq[i].fl);
         @(posedge clk); #1;
         get(sel);
         chk($sformatf("%s_valid_%0d", nm, i), {63'b0, ov}, {63'b0, sq[i].ev});
         chk($sformatf("%s_data_%0d", nm, i), eo, sq[i].ed);
      end
      reset = 1'b0;
      drv(sel, 1'b0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      sq.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic run_rand(input int sel, input int depth, input int dw, input int iw, input int n);
      logic        rst, iv, st, fl;
      logic [63:0] s;
      logic [2:0]  md;
      int          of;
      do_reset();
      m_step(depth, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
      for (int k = 0; k < n; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         iv  = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 4) == 0);
         fl  = ($urandom_range(0, 14) == 0);
         s   = {$urandom, $urandom};
         if (dw == 32) s[63:32] = '0;
         md  = 3'($urandom_range(0, 7));
         of  = int'($urandom_range(0, dw / 8 - 1));
         reset = rst;
         drv(sel, iv, s, md, 3'(of), st, fl);
         @(posedge clk); #1;
         m_step(depth, rst, iv, st, fl, ref_ext(dw, iw, md, of, s),
                ((md == 3'd5) || (md == 3'd6)) && of[0]);
         get(sel);
         chk("rnd_valid", {63'b0, ov}, {63'b0, m_lv});
         chk("rnd_data", eo, m_le);
         chk("rnd_mis", {63'b0, mi}, {63'b0, m_lm});
      end
      reset = 1'b0;
      drv(sel, 1'b0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0);
   endtask

   initial begin
      vec_t vt[14];
      vt[0]  = '{32'h0000_8001, 3'd0, 2'd0, 32'h0000_8001, 1'b0};
      vt[1]  = '{32'h0000_8001, 3'd1, 2'd0, 32'hFFFF_8001, 1'b0};
      vt[2]  = '{32'h0000_8001, 3'd2, 2'd3, 32'h8001_0000, 1'b0};
      vt[3]  = '{32'h80FF_7F01, 3'd4, 2'd2, 32'hFFFF_FFFF, 1'b0};
      vt[4]  = '{32'h80FF_7F01, 3'd3, 2'd3, 32'h0000_0080, 1'b0};
      vt[5]  = '{32'h80FF_7F01, 3'd6, 2'd2, 32'hFFFF_80FF, 1'b0};
      vt[6]  = '{32'h80FF_7F01, 3'd5, 2'd1, 32'h0000_7F01, 1'b1};
      vt[7]  = '{32'h80FF_7F01, 3'd6, 2'd3, 32'hFFFF_80FF, 1'b1};
      vt[8]  = '{32'h80FF_7F01, 3'd4, 2'd0, 32'h0000_0001, 1'b0};
      vt[9]  = '{32'h80FF_7F01, 3'd4, 2'd1, 32'h0000_007F, 1'b0};
      vt[10] = '{32'h80FF_7F01, 3'd3, 2'd2, 32'h0000_00FF, 1'b0};
      vt[11] = '{32'h1234_7FFF, 3'd1, 2'd1, 32'h0000_7FFF, 1'b0};
      vt[12] = '{32'hDEAD_BEEF, 3'd7, 2'd2, 32'hDEAD_BEEF, 1'b0};
      vt[13] = '{32'h80FF_7F01, 3'd5, 2'd2, 32'h0000_80FF, 1'b0};

      reset = 1'b1;
      drv(1, 1'b0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      drv(3, 1'b0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      drv(4, 1'b0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      for (int s = 1; s <= 4; s++) begin
         if (s == 2) continue;
         get(s);
         chk($sformatf("reset_valid_u%0d", s), {63'b0, ov}, 64'd0);
         chk($sformatf("reset_data_u%0d", s), eo, 64'd0);
         chk($sformatf("reset_mis_u%0d", s), {63'b0, mi}, 64'd0);
      end
      reset = 1'b0;

      // Single-stage vector table: result one edge after the request.
      foreach (vt[i]) begin
         drv(1, 1'b1, {32'b0, vt[i].s}, vt[i].m, {1'b0, vt[i].o}, 1'b0, 1'b0);
         @(posedge clk); #1;
         get(1);
         chk($sformatf("vec%0d_valid", i), {63'b0, ov}, 64'd1);
         chk($sformatf("vec%0d_data", i), eo, {32'b0, vt[i].e});
         chk($sformatf("vec%0d_mis", i), {63'b0, mi}, {63'b0, vt[i].mi});
      end
      drv(1, 1'b0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      get(1);
      chk("vec_idle_valid", {63'b0, ov}, 64'd0);
      chk("vec_idle_hold", eo, 64'h0000_80FF);

      // DEPTH=3 back-to-back A,B,C.
      do_reset();
      add(1, 64'h1111_1111, 0, 0, 0, 0, 64'h0);
      add(1, 64'h2222_2222, 0, 0, 0, 0, 64'h0);
      add(1, 64'h3333_3333, 0, 0, 0, 1, 64'h1111_1111);
      add(0, 64'h0,         0, 0, 0, 1, 64'h2222_2222);
      add(0, 64'h0,         0, 0, 0, 1, 64'h3333_3333);
      add(0, 64'h0,         0, 0, 0, 0, 64'h3333_3333);
      run_seq(3, "b2b");

      // DEPTH=3 stall for two cycles with the second request mid-pipe.
      add(1, 64'h4444_4444, 0, 0, 0, 0, 64'h3333_3333);
      add(1, 64'h5555_5555, 0, 0, 0, 0, 64'h3333_3333);
      add(1, 64'h6666_6666, 0, 0, 0, 1, 64'h4444_4444);
      add(0, 64'h0,         1, 0, 0, 1, 64'h4444_4444);
      add(0, 64'h0,         1, 0, 0, 1, 64'h4444_4444);
      add(0, 64'h0,         0, 0, 0, 1, 64'h5555_5555);
      add(0, 64'h0,         0, 0, 0, 1, 64'h6666_6666);
      add(0, 64'h0,         0, 0, 0, 0, 64'h6666_6666);
      run_seq(3, "stall");

      // DEPTH=3 flush together with stall and a new request.
      add(1, 64'h7777_7777, 0, 0, 0, 0, 64'h6666_6666);
      add(1, 64'h8888_8888, 0, 0, 0, 0, 64'h6666_6666);
      add(1, 64'h9999_9999, 0, 0, 0, 1, 64'h7777_7777);
      add(1, 64'hAAAA_AAAA, 1, 1, 0, 0, 64'h7777_7777);
      add(0, 64'h0,         0, 0, 0, 0, 64'h7777_7777);
      add(0, 64'h0,         0, 0, 0, 0, 64'h7777_7777);
      add(0, 64'h0,         0, 0, 0, 0, 64'h7777_7777);
      add(0, 64'h0,         0, 0, 0, 0, 64'h7777_7777);
      run_seq(3, "flush");

      // DEPTH=4 (64-bit): reset with requests in flight, then reset during
      // stall+flush with a valid result showing.
      do_reset();
      add(1, 64'h0102_0304_0506_0708, 0, 0, 0, 0, 64'h0);
      add(1, 64'h1112_1314_1516_1718, 0, 0, 0, 0, 64'h0);
      add(1, 64'h2122_2324_2526_2728, 0, 0, 0, 0, 64'h0);
      add(1, 64'h3132_3334_3536_3738, 0, 0, 1, 0, 64'h0);
      for (int k = 0; k < 5; k++) add(0, 64'h0, 0, 0, 0, 0, 64'h0);
      add(1, 64'hA1A2_A3A4_A5A6_A7A8, 0, 0, 0, 0, 64'h0);
      add(1, 64'hB1B2_B3B4_B5B6_B7B8, 0, 0, 0, 0, 64'h0);
      add(1, 64'hC1C2_C3C4_C5C6_C7C8, 0, 0, 0, 0, 64'h0);
      add(1, 64'hD1D2_D3D4_D5D6_D7D8, 0, 0, 0, 1, 64'hA1A2_A3A4_A5A6_A7A8);
      add(1, 64'hE1E2_E3E4_E5E6_E7E8, 1, 1, 1, 0, 64'h0);
      for (int k = 0; k < 5; k++) add(0, 64'h0, 0, 0, 0, 0, 64'h0);
      run_seq(4, "rst");

      run_rand(3, 3, 32, 16, 400);
      run_rand(4, 4, 64, 12, 400);
      run_rand(1, 1, 32, 16, 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IMM_W, default 16, width of the immediate field taken from src[IMM_W-1:0]; legal 1..DATA_W-1.
REQ-002 Parameter DATA_W, default 32, datapath width; legal values 32 or 64.
REQ-003 Parameter DEPTH, default 1, number of register stages from input to output; legal 1..4.
REQ-004 Derived OFF_W = log2(DATA_W/8), width of the byte offset: 2 for DATA_W=32, 3 for DATA_W=64.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  src/mode/off carry a valid request this cycle.
REQ-008 src  input  DATA_W  immediate source (low IMM_W bits) or raw load word.
REQ-009 mode  input  3  extension operation, encoding per REQ-015.
REQ-010 off  input  OFF_W  byte offset of a load within the word.
REQ-011 stall  input  1  hold every pipeline stage.
REQ-012 flush  input  1  kill every in-flight request.
REQ-013 out_valid  output  1  ext_out/misalign are valid this cycle.
REQ-014 ext_out  output  DATA_W  extended result; misalign  output  1  half-access with off[0]=1.

Function
REQ-015 Mode encoding:
- 0: zero-extend src[IMM_W-1:0].
- 1: sign-extend src[IMM_W-1:0].
- 2: upper: src[IMM_W-1:0] << (DATA_W-IMM_W), low bits 0.
- 3: unsigned byte, lane off.
- 4: signed byte, lane off.
- 5: unsigned half, lane off[OFF_W-1:1].
- 6: signed half, lane off[OFF_W-1:1].
- 7: pass src unchanged.
REQ-016 Byte lane k is bits 8k+7:8k; half lane k is bits 16k+15:16k; little-endian.
REQ-017 off is ignored in modes 0, 1, 2 and 7.
REQ-018 misalign is 1 only for mode 5 or 6 with off[0]=1; the result then uses the half lane of off[OFF_W-1:1], with off[0] ignored.
REQ-019 Extension is computed combinationally before stage 1; stages 2..DEPTH only delay it.
REQ-020 Latency: a request accepted at edge N appears on the outputs after edge N+DEPTH-1; with no stall or flush the pipe accepts one request per cycle.
REQ-021 A request is accepted when in_valid=1, stall=0, flush=0 and reset=0.
REQ-022 When stall=0, each stage loads from its predecessor; stage 1 loads valid=in_valid and the computed data.
REQ-023 When stall=1 and flush=0, all stage valid and data bits hold.
- Input is not sampled; upstream holds it.
REQ-024 When flush=1, all stage valid bits clear at the next edge regardless of stall.
- Data bits need not clear.
- A same-cycle in_valid is discarded.
REQ-025 Priority: reset > flush > stall > normal advance.
REQ-026 ext_out and misalign are driven from the last stage only; no combinational path from inputs to outputs.
REQ-027 When out_valid=0, ext_out and misalign hold their last registered values.
- Software relies only on out_valid.
REQ-028 mode, src and off are don't-care when in_valid=0.

Reset
REQ-029 On a rising edge with reset=1, every stage valid bit and every stage data/misalign register clears to 0.
REQ-030 After reset, out_valid=0, ext_out=0 and misalign=0 until the first accepted request has travelled DEPTH stages.
REQ-031 A reset during a stall or flush has the same effect as REQ-029.
- In-flight requests are lost.

Verification
REQ-032 DATA_W=32, IMM_W=16, DEPTH=1:
- src=0x0000_8001, mode 0 -> 0x0000_8001 one edge later.
- Same src, mode 1 -> 0xFFFF_8001.
- Same src, mode 2 -> 0x8001_0000.
REQ-033 Load lanes, src=0x80FF_7F01:
- mode 4 off=2 -> 0xFFFF_FFFF.
- mode 3 off=3 -> 0x0000_0080.
- mode 6 off=2 -> 0xFFFF_80FF, misalign=0.
- mode 5 off=1 -> 0x0000_7F01, misalign=1.
REQ-034 DEPTH=3, back-to-back requests A, B, C at edges 1..3 -> out_valid high after edges 3..5 carrying A, B, C, with no gaps.
REQ-035 DEPTH=3, stall=1 for 2 cycles while B is mid-pipe -> outputs frozen for 2 cycles, then the sequence resumes with no loss or duplication.
REQ-036 flush together with stall and in_valid -> out_valid=0 for the next DEPTH cycles; the new request is absent.
REQ-037 reset pulsed with 3 requests in flight (DEPTH=4) -> out_valid=0 and ext_out=0 on the next edge; no stale request ever emerges.
